// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch-stage address arithmetic.
package mips_pkg;

  localparam int XLEN           = 32;
  localparam int PC_INCR        = 4;
  localparam int JUMP_FIELD_MSB = 25;
  localparam int REGION_BITS    = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc_plus4;
    word_t jump_addr;
    word_t branch_addr;
  } addr_snap_t;

endpackage

// File: rtl/next_pc_addr_unit_if.sv
// Bus between the pc register/instruction memory side and the next-PC address unit.
interface next_pc_addr_unit_if;
  import mips_pkg::*;

  word_t curr_pc;
  word_t inst;
  word_t sign_ext_imm;
  logic  snap_en;

  word_t pc_plus4;
  word_t jump_addr;
  word_t branch_addr;
  word_t pc_plus4_q;
  word_t jump_addr_q;
  word_t branch_addr_q;

  modport master (
    output curr_pc, inst, sign_ext_imm, snap_en,
    input  pc_plus4, jump_addr, branch_addr,
    input  pc_plus4_q, jump_addr_q, branch_addr_q
  );

  modport slave (
    input  curr_pc, inst, sign_ext_imm, snap_en,
    output pc_plus4, jump_addr, branch_addr,
    output pc_plus4_q, jump_addr_q, branch_addr_q
  );

endinterface

// File: rtl/addr_adder32.sv
// Plain 32-bit modulo adder; the carry-out is deliberately dropped.
module addr_adder32
  import mips_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t sum
);

  assign sum = a + b;

endmodule

// File: rtl/next_pc_addr_unit.sv
// Fetch-stage PC+4, jump-target and branch-target formation, plus an
// enable-gated snapshot of all three addresses for debug/trace.
module next_pc_addr_unit
  import mips_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  next_pc_addr_unit_if.slave  bus
);

  word_t      pc_plus4;
  word_t      jump_addr;
  word_t      branch_offset;
  word_t      branch_addr;
  addr_snap_t snap_d;
  addr_snap_t snap_q;

  addr_adder32 u_pc_incr (
    .a   (bus.curr_pc),
    .b   (word_t'(PC_INCR)),
    .sum (pc_plus4)
  );

  // Region bits come from PC+4 so a jump in a region's last word lands in the next region.
  assign jump_addr = {pc_plus4[XLEN-1 -: REGION_BITS], bus.inst[JUMP_FIELD_MSB:0], 2'b00};

  // Top two immediate bits are redundant copies of bit 29 after sign extension.
  assign branch_offset = {bus.sign_ext_imm[XLEN-3:0], 2'b00};

  addr_adder32 u_branch_add (
    .a   (pc_plus4),
    .b   (branch_offset),
    .sum (branch_addr)
  );

  logic unused_bits;
  assign unused_bits = ^{bus.inst[XLEN-1:JUMP_FIELD_MSB+1], bus.sign_ext_imm[XLEN-1:XLEN-2]};

  // NOTE: default-assign first so every path writes snap_d; otherwise a latch is inferred.
  always_comb begin
    snap_d = snap_q;
    if (bus.snap_en) begin
      snap_d = '{pc_plus4: pc_plus4, jump_addr: jump_addr, branch_addr: branch_addr};
    end
  end

  // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) snap_q <= '0;
    else          snap_q <= snap_d;
  end

  assign bus.pc_plus4      = pc_plus4;
  assign bus.jump_addr     = jump_addr;
  assign bus.branch_addr   = branch_addr;
  assign bus.pc_plus4_q    = snap_q.pc_plus4;
  assign bus.jump_addr_q   = snap_q.jump_addr;
  assign bus.branch_addr_q = snap_q.branch_addr;

endmodule

// File: tb/tb_next_pc_addr_unit.sv
// Directed and randomized checks of next_pc_addr_unit against an arithmetic
// reference model of the fetch address rules and snapshot register behaviour.
module tb_next_pc_addr_unit;
  import mips_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  word_t exp_p4_q, exp_j_q, exp_b_q;

  always #5 clock = ~clock;

  next_pc_addr_unit_if bus ();

  next_pc_addr_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic word_t ref_p4(word_t pc);
    return pc + 32'd4;
  endfunction

  function automatic word_t ref_jump(word_t pc, word_t ins);
    word_t p4 = pc + 32'd4;
    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
  endfunction

  function automatic word_t ref_branch(word_t pc, word_t imm);
    return pc + 32'd4 + imm * 32'd4;
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input word_t pc, input word_t ins, input word_t imm,
                       input logic en, input logic rst_val);
    bus.curr_pc      = pc;
    bus.inst         = ins;
    bus.sign_ext_imm = imm;
    bus.snap_en      = en;
    reset_n          = rst_val;
    #1;
    check("pc_plus4",    bus.pc_plus4,    ref_p4(pc));
    check("jump_addr",   bus.jump_addr,   ref_jump(pc, ins));
    check("branch_addr", bus.branch_addr, ref_branch(pc, imm));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      exp_p4_q = '0; exp_j_q = '0; exp_b_q = '0;
    end else if (bus.snap_en) begin
      exp_p4_q = ref_p4(bus.curr_pc);
      exp_j_q  = ref_jump(bus.curr_pc, bus.inst);
      exp_b_q  = ref_branch(bus.curr_pc, bus.sign_ext_imm);
    end
    #1;
    check("pc_plus4_q",    bus.pc_plus4_q,    exp_p4_q);
    check("jump_addr_q",   bus.jump_addr_q,   exp_j_q);
    check("branch_addr_q", bus.branch_addr_q, exp_b_q);
  endtask

  initial begin
    word_t imm16;

    // Reset with snap_en high: reset wins.
    drive(32'h0040_0000, 32'h0810_0005, 32'h0, 1'b1, 1'b0);
    tick();
    check("rst_p4_q",   bus.pc_plus4_q,    32'h0);
    check("rst_j_q",    bus.jump_addr_q,   32'h0);
    check("rst_b_q",    bus.branch_addr_q, 32'h0);
    check("inc_basic",  bus.pc_plus4,      32'h0040_0004);
    check("jump_basic", bus.jump_addr,     32'h0040_0014);

    drive(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    check("inc_wrap", bus.pc_plus4, 32'h0000_0000);

    drive(32'h0FFF_FFFC, 32'h0800_0000, 32'h0, 1'b0, 1'b0);
    check("region_p4",   bus.pc_plus4,  32'h1000_0000);
    check("region_jump", bus.jump_addr, 32'h1000_0000);

    drive(32'h0040_0010, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("br_neg", bus.branch_addr, 32'h0040_000C);
    drive(32'h0040_0010, 32'h0, 32'h0000_0003, 1'b0, 1'b0);
    check("br_pos", bus.branch_addr, 32'h0040_0020);
    drive(32'h0040_0010, 32'h0, 32'h0, 1'b0, 1'b0);
    check("br_zero", bus.branch_addr, 32'h0040_0014);

    // Capture after reset release, then hold with snap_en low.
    drive(32'h0040_0000, 32'h0810_0005, 32'h1, 1'b1, 1'b1);
    tick();
    check("snap_p4_q", bus.pc_plus4_q,    32'h0040_0004);
    check("snap_j_q",  bus.jump_addr_q,   32'h0040_0014);
    check("snap_b_q",  bus.branch_addr_q, 32'h0040_0008);

    drive(32'h1234_5670, 32'h0ABC_DEF0, 32'hFFFF_FF00, 1'b0, 1'b1);
    tick();
    tick();
    check("hold_p4_q", bus.pc_plus4_q,    32'h0040_0004);
    check("hold_j_q",  bus.jump_addr_q,   32'h0040_0014);
    check("hold_b_q",  bus.branch_addr_q, 32'h0040_0008);

    // Mid-run reset clears the snapshot only.
    drive(32'h0050_0000, 32'h0810_0005, 32'h1, 1'b1, 1'b0);
    tick();
    check("midrst_p4_q", bus.pc_plus4_q,    32'h0);
    check("midrst_j_q",  bus.jump_addr_q,   32'h0);
    check("midrst_b_q",  bus.branch_addr_q, 32'h0);
    check("midrst_p4",   bus.pc_plus4,      32'h0050_0004);

    for (int i = 0; i < 300; i++) begin
      imm16 = {{16{1'b0}}, 16'($urandom)};
      if (imm16[15]) imm16 = imm16 | 32'hFFFF_0000;
      drive({$urandom} & 32'hFFFF_FFFC, $urandom, imm16,
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
